// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder (cla_adder_pipe).
// Optional subtract mode is enabled by defining CLA_PIPE_SUB_EN.
package cla_pkg;

   localparam int GRP_W = 4;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // Per-stage control record; the partial sum lives beside it because its width varies by stage.
   typedef struct packed {
      logic vld;
      logic carry;
   } stg_ctl_t;

   function automatic int nstg(input int width, input int grp_per_stg);
      return width / (GRP_W * grp_per_stg);
   endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for cla_adder_pipe; in_sub exists only when
// CLA_PIPE_SUB_EN is defined.
interface cla_adder_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
`ifdef CLA_PIPE_SUB_EN
   logic             in_sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   modport master (
`ifdef CLA_PIPE_SUB_EN
      output in_sub,
`endif
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   modport slave (
`ifdef CLA_PIPE_SUB_EN
      input  in_sub,
`endif
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );

endinterface

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead group; c3 is the carry into bit 3 for overflow detection.
module cla4_group
   import cla_pkg::*;
(
   input  logic [GRP_W-1:0] a,
   input  logic [GRP_W-1:0] b,
   input  logic             cin,
   output logic [GRP_W-1:0] sum,
   output logic             cout,
   output logic             c3
);
   gp_t  [GRP_W-1:0] gp;
   logic [GRP_W-1:0] g;
   logic [GRP_W-1:0] p;
   logic [GRP_W:0]   c;

   always_comb begin
      for (int i = 0; i < GRP_W; i++) begin
         gp[i].g = a[i] & b[i];
         gp[i].p = a[i] | b[i];
         g[i]    = gp[i].g;
         p[i]    = gp[i].p;
      end
   end

   // Every carry is formed directly from cin, not rippled through the previous bit.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = a ^ b ^ c[GRP_W-1:0];
   assign cout = c[GRP_W];
   assign c3   = c[GRP_W-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder with valid/ready flow control, one 4-bit group slice per stage.
// Define CLA_PIPE_SUB_EN to add the in_sub port (A-B mode).
module cla_adder_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int GRP_PER_STG = 1
) (
   input  logic            clk,
   input  logic            rst,
   cla_adder_pipe_if.slave bus
);
   localparam int NSTG = nstg(WIDTH, GRP_PER_STG);
   localparam int SW   = GRP_W * GRP_PER_STG;

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [NSTG:0]    ready;

`ifdef CLA_PIPE_SUB_EN
   assign b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
   assign cin_eff = bus.in_sub | bus.in_cin;
`else
   assign b_eff   = bus.in_b;
   assign cin_eff = bus.in_cin;
`endif

   assign ready[NSTG]  = bus.out_ready;
   assign bus.in_ready = ready[0] & ~rst;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int LO = k * SW;

      logic [WIDTH-1:LO]      src_a;
      logic [WIDTH-1:LO]      src_b;
      logic                   src_c;
      logic                   src_vld;
      logic                   load;
      logic [SW-1:0]          grp_sum;
      logic [LO+SW-1:0]       nxt_sum;
      logic [LO+SW-1:0]       sum_p;
      logic [GRP_PER_STG:0]   cc;
      logic [GRP_PER_STG-1:0] c3;
      logic                   unused_c3;
      stg_ctl_t               ctl_p;

      // Stage boundary: operands enter from the bus or from the previous stage's skewed upper bits.
      if (k == 0) begin : g_head
         assign src_a   = bus.in_a;
         assign src_b   = b_eff;
         assign src_c   = cin_eff;
         assign src_vld = bus.in_valid & bus.in_ready;
         assign nxt_sum = grp_sum;
      end else begin : g_body
         assign src_a   = g_stg[k-1].g_fwd.a_p;
         assign src_b   = g_stg[k-1].g_fwd.b_p;
         assign src_c   = g_stg[k-1].ctl_p.carry;
         assign src_vld = g_stg[k-1].ctl_p.vld;
         assign nxt_sum = {grp_sum, g_stg[k-1].sum_p};
      end

      assign cc[0] = src_c;
      for (genvar g = 0; g < GRP_PER_STG; g++) begin : g_grp
         cla4_group u_grp (
            .a   (src_a[LO+g*GRP_W +: GRP_W]),
            .b   (src_b[LO+g*GRP_W +: GRP_W]),
            .cin (cc[g]),
            .sum (grp_sum[g*GRP_W +: GRP_W]),
            .cout(cc[g+1]),
            .c3  (c3[g])
         );
      end
      // Only the top group of the whole word needs its carry-into-bit-3 tap.
      assign unused_c3 = ^c3;

      assign ready[k] = ~ctl_p.vld | ready[k+1];
      assign load     = ready[k] & src_vld;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ctl_p <= '0;
            sum_p <= '0;
         end else begin
            if (ready[k]) ctl_p.vld <= src_vld;
            if (load) begin
               ctl_p.carry <= cc[GRP_PER_STG];
               sum_p       <= nxt_sum;
            end
         end
      end

      if (k < NSTG-1) begin : g_fwd
         logic [WIDTH-1:LO+SW] a_p;
         logic [WIDTH-1:LO+SW] b_p;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_p <= '0;
               b_p <= '0;
            end else if (load) begin
               a_p <= src_a[WIDTH-1:LO+SW];
               b_p <= src_b[WIDTH-1:LO+SW];
            end
         end
      end else begin : g_tail
         logic msb_p;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)       msb_p <= 1'b0;
            else if (load) msb_p <= c3[GRP_PER_STG-1];
         end
      end
   end

   // Output boundary: the last stage register drives the result bus directly.
   assign bus.out_valid = g_stg[NSTG-1].ctl_p.vld;
   assign bus.out_sum   = g_stg[NSTG-1].sum_p;
   assign bus.out_cout  = g_stg[NSTG-1].ctl_p.carry;
   assign bus.out_ovf   = g_stg[NSTG-1].ctl_p.carry ^ g_stg[NSTG-1].g_tail.msb_p;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe (WIDTH=16, GRP_PER_STG=1); covers in_sub when CLA_PIPE_SUB_EN is defined.
module tb_cla_adder_pipe;
   localparam int WIDTH = 16;
   localparam int GPS   = 1;

   logic clk = 1'b0;
   logic rst;
   logic cur_sub;

   always #5 clk = ~clk;

   cla_adder_pipe_if #(.WIDTH(WIDTH)) bus ();

   cla_adder_pipe #(.WIDTH(WIDTH), .GRP_PER_STG(GPS)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pops = 0;
   int first_pop = -1;
   int last_pop = -1;
   logic [17:0] exp_q[$];

   // Reference: {ovf, cout, sum} from integer arithmetic on the operands.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
      int ua, ub, sa, sb, ci, u, s;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      ci = int'(cin);
      if (sub) begin
         u = ua - ub;
         s = sa - sb;
         return {(s > 32767 || s < -32768), (ua >= ub), u[15:0]};
      end
      u = ua + ub + ci;
      s = sa + sb + ci;
      return {(s > 32767 || s < -32768), (u > 65535), u[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s);
      bus.in_valid = v;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = c;
      cur_sub      = s;
`ifdef CLA_PIPE_SUB_EN
      bus.in_sub   = s;
`endif
   endtask

   task automatic step();
      logic [17:0] e;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL out_extra observed=%0h expected=none", bus.out_sum);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_result", {14'd0, bus.out_ovf, bus.out_cout, bus.out_sum}, {14'd0, e});
         end
         pops++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
      if (bus.in_valid && bus.in_ready)
         exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, cur_sub));
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      while (!bus.out_valid && n < 12) begin
         step();
         n++;
      end
      check(tag, 32'(bus.out_valid), 32'd1);
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check({tag, "_empty"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_idle"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] held;
      int          qs;
      int          p0;

      rst           = 1'b1;
      bus.out_ready = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_bits", {13'd0, bus.out_ovf, bus.out_cout, bus.out_sum}, 32'd0);
      rst = 1'b0;
      #1;
      check("rel_in_ready", 32'(bus.in_ready), 32'd1);

      // 0xFFFF + 1 with exact latency
      bus.out_ready = 1'b1;
      drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      check("t1_lat3_valid", 32'(bus.out_valid), 32'd0);
      step();
      check("t1_lat4_valid", 32'(bus.out_valid), 32'd1);
      check("t1_result", {14'd0, bus.out_ovf, bus.out_cout, bus.out_sum}, {14'd0, 1'b0, 1'b1, 16'h0000});
      drain("t1", 10);

      // signed overflow corners
      drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0);
      step();
      bus.in_valid = 1'b0;
      wait_out("t2_seen");
      check("t2_pos_ovf", {14'd0, bus.out_ovf, bus.out_cout, bus.out_sum}, {14'd0, 1'b1, 1'b0, 16'h8000});
      step();
      check("t2_neg_ovf", {14'd0, bus.out_ovf, bus.out_cout, bus.out_sum}, {14'd0, 1'b1, 1'b1, 16'h0000});
      drain("t2", 10);

      // 8 back-to-back random beats
      pops = 0;
      first_pop = -1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
         check("t3_in_ready", 32'(bus.in_ready), 32'd1);
         step();
      end
      drain("t3", 20);
      check("t3_count", 32'(pops), 32'd8);
      check("t3_consecutive", 32'(last_pop - first_pop), 32'd7);

      // stall the output for 6 cycles
      bus.out_ready = 1'b0;
      drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < 6; i++) begin
         qs = exp_q.size();
         step();
         if (exp_q.size() != qs)
            drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
      end
      check("t4_accepted", 32'(exp_q.size()), 32'd4);
      check("t4_in_ready", 32'(bus.in_ready), 32'd0);
      check("t4_out_valid", 32'(bus.out_valid), 32'd1);
      held = bus.out_sum;
      step();
      step();
      check("t4_hold", 32'(bus.out_sum), 32'(held));
      p0 = pops;
      drain("t4", 20);
      check("t4_drained", 32'(pops - p0), 32'd4);

      // reset mid-flight discards everything
      bus.out_ready = 1'b1;
      drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h4321, 16'h2222, 1'b1, 1'b0);
      step();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
      check("t5_rst_bits", {13'd0, bus.out_ovf, bus.out_cout, bus.out_sum}, 32'd0);
      check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("t5_in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         check("t5_silent", 32'(bus.out_valid), 32'd0);
      end

`ifdef CLA_PIPE_SUB_EN
      // subtract mode
      drive(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1);
      step();
      drive(1'b1, 16'h0009, 16'h0003, 1'b1, 1'b1);
      step();
      bus.in_valid = 1'b0;
      wait_out("t6_seen");
      check("t6_sub", {15'd0, bus.out_cout, bus.out_sum}, {15'd0, 1'b0, 16'hFFFE});
      step();
      check("t6_sub_cin_ignored", {15'd0, bus.out_cout, bus.out_sum}, {15'd0, 1'b1, 16'h0006});
      drain("t6", 10);
`endif

      // random traffic with random backpressure
      for (int i = 0; i < 60; i++) begin
`ifdef CLA_PIPE_SUB_EN
         drive(1'($urandom_range(0, 1)), 16'($urandom()), 16'($urandom()),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
         drive(1'($urandom_range(0, 1)), 16'($urandom()), 16'($urandom()),
               1'($urandom_range(0, 1)), 1'b0);
`endif
         bus.out_ready = 1'($urandom_range(0, 1));
         step();
      end
      drain("rand", 40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
